// File: rtl/fnd_scan_controller.sv
// Multiplexed 7-segment (FND) scan controller.
// Walks one digit per scan tick across DIGITS common lines. The active page is
// chosen once per frame, at digit 0. Each digit can be blanked by the blink
// phase (per-digit mask) and by leading-zero blanking. Both outputs are
// registered and active-low.
//
// Ports
//   clk          : system clock, rising edge
//   rst          : asynchronous, active-high reset
//   i_bcd        : PAGES*DIGITS nibbles; nibble [p*DIGITS+d] is page p, digit d (d=0 rightmost)
//   i_dp         : decimal-point request per page/digit, same indexing
//   i_blink_mask : blink enable per page/digit, same indexing
//   i_page_sel   : requested page, taken at the start of each frame
//   i_lz_blank   : leading-zero blanking enable
//   fnd_com      : active-low digit enables
//   fnd_data     : active-low segments {dp,g,f,e,d,c,b,a}
module fnd_scan_controller #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned SCAN_HZ     = 1000,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned PAGES       = 2,
    parameter int unsigned BLINK_TICKS = 250
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PAGES*DIGITS*4-1:0]     i_bcd,
    input  logic [PAGES*DIGITS-1:0]       i_dp,
    input  logic [PAGES*DIGITS-1:0]       i_blink_mask,
    input  logic [$clog2(PAGES)-1:0]      i_page_sel,
    input  logic                          i_lz_blank,
    output logic [DIGITS-1:0]             fnd_com,
    output logic [7:0]                    fnd_data
);

    localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
    localparam int unsigned CW  = $clog2(DIV);
    localparam int unsigned IW  = $clog2(DIGITS);
    localparam int unsigned PW  = $clog2(PAGES);
    localparam int unsigned BW  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    // Flat input buses viewed as [page][digit]; packed layout matches the flat indexing.
    logic [PAGES-1:0][DIGITS-1:0][3:0] bcd_pk;
    logic [PAGES-1:0][DIGITS-1:0]      dp_pk;
    logic [PAGES-1:0][DIGITS-1:0]      mask_pk;

    assign bcd_pk  = i_bcd;
    assign dp_pk   = i_dp;
    assign mask_pk = i_blink_mask;

    logic [CW-1:0] presc_q;
    logic [IW-1:0] idx_q;
    logic [PW-1:0] page_q;
    logic [BW-1:0] blink_cnt_q;
    logic          blink_ph_q;

    logic              tick_c;
    logic [PW-1:0]     sel_ok_c;
    logic [PW-1:0]     eff_page_c;
    logic [DIGITS-1:0] zero_c;
    logic [DIGITS-1:0] lz_run_c;
    logic [3:0]        cur_bcd_c;
    logic              blank_c;
    logic [7:0]        seg_c;

    function automatic logic [7:0] seg_decode(input logic [3:0] code);
        case (code)
            4'h0:    seg_decode = 8'hC0;
            4'h1:    seg_decode = 8'hF9;
            4'h2:    seg_decode = 8'hA4;
            4'h3:    seg_decode = 8'hB0;
            4'h4:    seg_decode = 8'h99;
            4'h5:    seg_decode = 8'h92;
            4'h6:    seg_decode = 8'h82;
            4'h7:    seg_decode = 8'hF8;
            4'h8:    seg_decode = 8'h80;
            4'h9:    seg_decode = 8'h90;
            4'hA:    seg_decode = 8'hBF;
            default: seg_decode = 8'hFF;
        endcase
    endfunction

    assign tick_c = (presc_q == DIV_LAST);

    // Out-of-range page requests (non power-of-two PAGES) fall back to page 0.
    assign sel_ok_c = (32'(i_page_sel) < PAGES) ? i_page_sel : '0;

    // Digit 0 opens a new frame, so it already uses the freshly requested page.
    assign eff_page_c = (idx_q == '0) ? sel_ok_c : page_q;

    // lz_run_c[d]: digit d and every digit above it are zero on the active page.
    for (genvar d = 0; d < DIGITS; d++) begin : g_zero
        assign zero_c[d] = (bcd_pk[eff_page_c][d] == 4'd0);
        if (d == DIGITS - 1) begin : g_top
            assign lz_run_c[d] = zero_c[d];
        end else begin : g_chain
            assign lz_run_c[d] = zero_c[d] & lz_run_c[d+1];
        end
    end

    assign cur_bcd_c = bcd_pk[eff_page_c][idx_q];

    assign blank_c = (i_lz_blank && (idx_q != '0) && lz_run_c[idx_q])
                   || (blink_ph_q && mask_pk[eff_page_c][idx_q]);

    // Segment pattern for the digit about to be driven.
    always_comb begin
        seg_c = seg_decode(cur_bcd_c);
        if (dp_pk[eff_page_c][idx_q]) begin
            seg_c[7] = 1'b0;
        end
        if (blank_c) begin
            seg_c = 8'hFF;
        end
    end

    // Prescaler, digit walk, frame page latch, blink timer and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            idx_q       <= '0;
            page_q      <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            fnd_com     <= '1;
            fnd_data    <= 8'hFF;
        end else begin
            presc_q <= tick_c ? '0 : presc_q + CW'(1);
            if (tick_c) begin
                idx_q    <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
                fnd_com  <= ~(DIGITS'(1) << idx_q);
                fnd_data <= seg_c;
                if (idx_q == '0) begin
                    page_q <= sel_ok_c;
                end
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_q <= '0;
                    blink_ph_q  <= ~blink_ph_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + BW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Directed bench for fnd_scan_controller: 4 digits, 2 pages, 10 clocks per
// scan tick, blink half-period of 4 ticks. Outputs are sampled on the falling edge.
module tb_fnd_scan_controller;

    logic        clk;
    logic        rst;
    logic [31:0] i_bcd;
    logic [7:0]  i_dp;
    logic [7:0]  i_blink_mask;
    logic [0:0]  i_page_sel;
    logic        i_lz_blank;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;

    int n_checks = 0;
    int n_fail   = 0;

    fnd_scan_controller #(
        .CLK_HZ      (100),
        .SCAN_HZ     (10),
        .DIGITS      (4),
        .PAGES       (2),
        .BLINK_TICKS (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_bcd        (i_bcd),
        .i_dp         (i_dp),
        .i_blink_mask (i_blink_mask),
        .i_page_sel   (i_page_sel),
        .i_lz_blank   (i_lz_blank),
        .fnd_com      (fnd_com),
        .fnd_data     (fnd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [3:0] ecom, input logic [7:0] edata);
        check_eq({tag, "_com"},  32'(fnd_com),  32'(ecom));
        check_eq({tag, "_data"}, 32'(fnd_data), 32'(edata));
    endtask

    // n rising edges, then park on the following falling edge
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // hold reset across one edge, release on a falling edge
    task automatic do_reset;
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
    endtask

    logic [7:0] exp_a [4];
    logic [3:0] com_of [4];

    initial begin
        exp_a  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};
        com_of = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        rst          = 1'b1;
        i_bcd        = {16'h9876, 16'h3210};
        i_dp         = '0;
        i_blink_mask = '0;
        i_page_sel   = 1'b0;
        i_lz_blank   = 1'b0;

        // basic scan after reset
        adv(2);
        expect_out("rst_hold", 4'b1111, 8'hFF);
        rst = 1'b0;
        adv(9);
        expect_out("pre_tick", 4'b1111, 8'hFF);
        adv(1);
        expect_out("scan_k0", com_of[0], exp_a[0]);
        for (int k = 1; k < 8; k++) begin
            adv(9);
            expect_out($sformatf("scan_hold%0d", k), com_of[(k-1)%4], exp_a[(k-1)%4]);
            adv(1);
            expect_out($sformatf("scan_k%0d", k), com_of[k%4], exp_a[k%4]);
        end

        // leading-zero blanking
        i_bcd      = {16'h0000, 16'h0005};
        i_lz_blank = 1'b1;
        do_reset();
        adv(10); expect_out("lz5_d0", 4'b1110, 8'h92);
        adv(10); expect_out("lz5_d1", 4'b1101, 8'hFF);
        adv(10); expect_out("lz5_d2", 4'b1011, 8'hFF);
        adv(10); expect_out("lz5_d3", 4'b0111, 8'hFF);
        i_bcd[15:0] = 16'h0000;
        adv(10); expect_out("lz0_d0", 4'b1110, 8'hC0);
        adv(10); expect_out("lz0_d1", 4'b1101, 8'hFF);
        adv(10); expect_out("lz0_d2", 4'b1011, 8'hFF);
        adv(10); expect_out("lz0_d3", 4'b0111, 8'hFF);
        i_bcd[15:0] = 16'h0100;
        adv(10); expect_out("lzi_d0", 4'b1110, 8'hC0);
        adv(10); expect_out("lzi_d1", 4'b1101, 8'hC0);
        adv(10); expect_out("lzi_d2", 4'b1011, 8'hF9);
        adv(10); expect_out("lzi_d3", 4'b0111, 8'hFF);

        // blink on digit 1 (with its dp requested)
        i_bcd        = {16'h0000, 16'h0010};
        i_lz_blank   = 1'b0;
        i_blink_mask = 8'b0000_0010;
        i_dp         = 8'b0000_0010;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            adv(10);
            expect_out($sformatf("blk_f%0d_d0", f), 4'b1110, 8'hC0);
            adv(10);
            expect_out($sformatf("blk_f%0d_d1", f), 4'b1101, (f % 2 == 1) ? 8'hFF : 8'h79);
            adv(20);
        end

        // page change mid-frame
        i_bcd        = {16'h7654, 16'h3210};
        i_blink_mask = '0;
        i_dp         = '0;
        i_page_sel   = 1'b0;
        do_reset();
        adv(10); expect_out("pg_d0", 4'b1110, 8'hC0);
        adv(10); expect_out("pg_d1", 4'b1101, 8'hF9);
        i_page_sel = 1'b1;
        adv(10); expect_out("pg_d2_old", 4'b1011, 8'hA4);
        adv(10); expect_out("pg_d3_old", 4'b0111, 8'hB0);
        adv(10); expect_out("pg_d0_new", 4'b1110, 8'h99);
        adv(10); expect_out("pg_d1_new", 4'b1101, 8'h92);
        adv(10); expect_out("pg_d2_new", 4'b1011, 8'h82);
        adv(10); expect_out("pg_d3_new", 4'b0111, 8'hF8);

        // decimal point, and dp suppressed on an lz-blanked digit
        i_page_sel = 1'b0;
        i_bcd      = {16'h0000, 16'h0210};
        i_dp       = 8'b0000_1100;
        i_lz_blank = 1'b1;
        do_reset();
        adv(10); expect_out("dp_d0", 4'b1110, 8'hC0);
        adv(10); expect_out("dp_d1", 4'b1101, 8'hF9);
        adv(10); expect_out("dp_d2", 4'b1011, 8'h24);
        adv(10); expect_out("dp_d3_blank", 4'b0111, 8'hFF);

        // page 1 selected at release; dash and invalid codes
        i_dp       = '0;
        i_lz_blank = 1'b0;
        i_bcd      = {16'hFBA9, 16'h3210};
        i_page_sel = 1'b1;
        do_reset();
        adv(10); expect_out("code9", 4'b1110, 8'h90);
        adv(10); expect_out("codeA", 4'b1101, 8'hBF);
        adv(10); expect_out("codeB", 4'b1011, 8'hFF);
        adv(10); expect_out("codeF", 4'b0111, 8'hFF);

        // asynchronous reset between edges during digit 2
        i_page_sel = 1'b0;
        do_reset();
        adv(30);
        expect_out("mid_d2", 4'b1011, 8'hA4);
        #2 rst = 1'b1;
        #1 expect_out("async_rst", 4'b1111, 8'hFF);
        #1 rst = 1'b0;
        adv(9); expect_out("rel_pre", 4'b1111, 8'hFF);
        adv(1); expect_out("rel_d0", 4'b1110, 8'hC0);
        adv(10); expect_out("rel_d1", 4'b1101, 8'hF9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

endmodule
